crypto_dispatcher: RTL

Parametrised request dispatcher that sits between the system's command source and the encrypt, decrypt and password-generation engines. It supersedes the plain mode-select wrapper:
- requests are queued in a FIFO with a valid/ready handshake;
- each request is issued to exactly one engine with a start/done handshake;
- results return on a registered response channel tagged with mode and error status.

Widths, queue depth and engine timeout are parameters.

---
 rtl/crypto_dispatcher_if.sv | 48 ++++
 rtl/crypto_dispatcher.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/crypto_dispatcher_if.sv
// Request, engine and response channels of crypto_dispatcher.
// Modport slave is the dispatcher; master is the command source / engine side.
interface crypto_dispatcher_if #(
   parameter int unsigned PLAIN_W  = 60,
   parameter int unsigned CIPHER_W = 78
);
   logic                req_valid;
   logic                req_ready;
   logic [1:0]          req_mode;
   logic [CIPHER_W-1:0] req_data;

   logic                enc_start;
   logic                dec_start;
   logic                pg_start;
   logic [PLAIN_W-1:0]  enc_din;
   logic [CIPHER_W-1:0] dec_din;
   logic                enc_done;
   logic                dec_done;
   logic                pg_done;
   logic [CIPHER_W-1:0] enc_dout;
   logic [PLAIN_W-1:0]  dec_dout;
   logic [PLAIN_W-1:0]  pg_dout;

   logic                rsp_valid;
   logic                rsp_ready;
   logic [1:0]          rsp_mode;
   logic [CIPHER_W-1:0] rsp_data;
   logic                rsp_err;
   logic                busy;

   modport slave (
      input  req_valid, req_mode, req_data,
      output req_ready,
      output enc_start, dec_start, pg_start, enc_din, dec_din,
      input  enc_done, dec_done, pg_done, enc_dout, dec_dout, pg_dout,
      output rsp_valid, rsp_mode, rsp_data, rsp_err, busy,
      input  rsp_ready
   );

   modport master (
      output req_valid, req_mode, req_data,
      input  req_ready,
      input  enc_start, dec_start, pg_start, enc_din, dec_din,
      output enc_done, dec_done, pg_done, enc_dout, dec_dout, pg_dout,
      input  rsp_valid, rsp_mode, rsp_data, rsp_err, busy,
      output rsp_ready
   );
endinterface

// File: rtl/crypto_dispatcher.sv
// Queues requests in a FIFO and issues each to one engine, returning a tagged response.
// Define CRYPTO_DISPATCH_TIMEOUT_EN to bound the wait for an engine done by TIMEOUT cycles.
module crypto_dispatcher #(
   parameter int unsigned PLAIN_W  = 60,
   parameter int unsigned CIPHER_W = 78,
   parameter int unsigned DEPTH    = 4,
   parameter int unsigned TIMEOUT  = 255
) (
   input  logic               Clk,
   input  logic               Rst_n,
   crypto_dispatcher_if.slave bus
);

   localparam int unsigned AW   = $clog2(DEPTH);
   localparam int unsigned PtrW = AW + 1;

   if (CIPHER_W < PLAIN_W || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT == 0)
   begin : g_param_err
      $error("crypto_dispatcher: illegal parameter set");
   end

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

   logic [1:0]          r_fifo_mode [DEPTH];
   logic [CIPHER_W-1:0] r_fifo_data [DEPTH];
   logic [PtrW-1:0]     r_wr_ptr;
   logic [PtrW-1:0]     r_rd_ptr;

   state_e              r_state;
   logic [1:0]          r_mode;
   logic [CIPHER_W-1:0] r_data;
   logic                r_enc_start;
   logic                r_dec_start;
   logic                r_pg_start;
   logic                r_rsp_valid;
   logic [1:0]          r_rsp_mode;
   logic [CIPHER_W-1:0] r_rsp_data;
   logic                r_rsp_err;

`ifdef CRYPTO_DISPATCH_TIMEOUT_EN
   localparam int unsigned CntW = $clog2(TIMEOUT + 1);
   logic [CntW-1:0]     r_cnt;
`endif

   logic                w_full;
   logic                w_empty;
   logic                w_push;
   logic                w_pop;
   logic [1:0]          w_head_mode;
   logic [CIPHER_W-1:0] w_head_data;
   logic                w_sel_done;
   logic [CIPHER_W-1:0] w_sel_dout;

   // Extra pointer MSB distinguishes full from empty.
   assign w_empty     = (r_wr_ptr == r_rd_ptr);
   assign w_full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                        (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_push      = bus.req_valid && !w_full;
   assign w_pop       = (r_state == StIdle) && !w_empty;
   assign w_head_mode = r_fifo_mode[r_rd_ptr[AW-1:0]];
   assign w_head_data = r_fifo_data[r_rd_ptr[AW-1:0]];

   always_ff @(posedge Clk) begin
      if (w_push) begin
         r_fifo_mode[r_wr_ptr[AW-1:0]] <= bus.req_mode;
         r_fifo_data[r_wr_ptr[AW-1:0]] <= bus.req_data;
      end
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PtrW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PtrW'(1);
      end
   end

   // Only the selected engine's done counts; PLAIN_W results are zero-extended.
   always_comb begin
      w_sel_done = 1'b0;
      w_sel_dout = '0;
      case (r_mode)
         2'b00: begin
            w_sel_done = bus.enc_done;
            w_sel_dout = bus.enc_dout;
         end
         2'b01: begin
            w_sel_done = bus.dec_done;
            w_sel_dout = CIPHER_W'(bus.dec_dout);
         end
         2'b10: begin
            w_sel_done = bus.pg_done;
            w_sel_dout = CIPHER_W'(bus.pg_dout);
         end
         default: ;
      endcase
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         r_state     <= StIdle;
         r_mode      <= 2'b00;
         r_data      <= '0;
         r_enc_start <= 1'b0;
         r_dec_start <= 1'b0;
         r_pg_start  <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_mode  <= 2'b00;
         r_rsp_data  <= '0;
         r_rsp_err   <= 1'b0;
`ifdef CRYPTO_DISPATCH_TIMEOUT_EN
         r_cnt       <= '0;
`endif
      end else begin
         r_enc_start <= 1'b0;
         r_dec_start <= 1'b0;
         r_pg_start  <= 1'b0;
         unique case (r_state)
            StIdle: begin
               if (!w_empty) begin
                  r_mode      <= w_head_mode;
                  r_data      <= w_head_data;
                  // Start is registered here so it is high exactly during ISSUE.
                  r_enc_start <= (w_head_mode == 2'b00);
                  r_dec_start <= (w_head_mode == 2'b01);
                  r_pg_start  <= (w_head_mode == 2'b10);
                  r_state     <= StIssue;
               end
            end
            StIssue: begin
               r_rsp_mode <= r_mode;
               if (r_mode == 2'b11) begin
                  r_rsp_err   <= 1'b1;
                  r_rsp_data  <= '0;
                  r_rsp_valid <= 1'b1;
                  r_state     <= StResp;
               end else begin
`ifdef CRYPTO_DISPATCH_TIMEOUT_EN
                  r_cnt   <= '0;
`endif
                  r_state <= StWait;
               end
            end
            StWait: begin
               if (w_sel_done) begin
                  r_rsp_data  <= w_sel_dout;
                  r_rsp_err   <= 1'b0;
                  r_rsp_valid <= 1'b1;
                  r_state     <= StResp;
               end
`ifdef CRYPTO_DISPATCH_TIMEOUT_EN
               else if (r_cnt == CntW'(TIMEOUT - 1)) begin
                  r_rsp_data  <= '0;
                  r_rsp_err   <= 1'b1;
                  r_rsp_valid <= 1'b1;
                  r_state     <= StResp;
               end else begin
                  r_cnt <= r_cnt + CntW'(1);
               end
`endif
            end
            StResp: begin
               if (bus.rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_state     <= StIdle;
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign bus.req_ready = !w_full;
   assign bus.enc_start = r_enc_start;
   assign bus.dec_start = r_dec_start;
   assign bus.pg_start  = r_pg_start;
   assign bus.enc_din   = r_data[PLAIN_W-1:0];
   assign bus.dec_din   = r_data;
   assign bus.rsp_valid = r_rsp_valid;
   assign bus.rsp_mode  = r_rsp_mode;
   assign bus.rsp_data  = r_rsp_data;
   assign bus.rsp_err   = r_rsp_err;
   assign bus.busy      = (r_state != StIdle) || !w_empty;

endmodule
